// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 exception codes, register addresses, field positions and packing helpers
package cp0_pkg;

    localparam logic [4:0] EXC_NONE = 5'd31;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int IP_HI   = 15;
    localparam int IP_LO   = 10;
    localparam int EXC_HI  = 6;
    localparam int EXC_LO  = 2;

    typedef enum logic {
        NORMAL = 1'b0,
        EXCLVL = 1'b1
    } exl_e;

    function automatic logic [31:0] sr_word(input logic [5:0] im, input logic exl, input logic ie);
        logic [31:0] w;
        w = '0;
        w[IM_HI:IM_LO] = im;
        w[EXL_BIT] = exl;
        w[IE_BIT] = ie;
        return w;
    endfunction

    function automatic logic [31:0] cause_word(input logic bd, input logic [5:0] ip, input logic [4:0] exc);
        logic [31:0] w;
        w = '0;
        w[BD_BIT] = bd;
        w[IP_HI:IP_LO] = ip;
        w[EXC_HI:EXC_LO] = exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0.sv
// cp0: MIPS coprocessor 0 holding SR/Cause/EPC/PRId, raising IntReq and serving mfc0/mtc0/eret
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h4C57_2018,
    parameter logic [5:0]  IM_RST   = 6'b000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic        EXLClr,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCode,
    input  logic [5:0]  HWInt,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    exl_e        exl_q, exl_d;
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic        int_hit, exc_hit;

    // request terms: everything is masked while at exception level
    always_comb begin
        int_hit = |(HWInt & im_q) & ie_q & (exl_q == NORMAL);
        exc_hit = (ExcCode != EXC_NONE) & (exl_q == NORMAL);
    end

    assign IntReq = int_hit | exc_hit;
    assign EPC    = epc_q;
    assign DOut   = (A1 == CP0_SR)    ? sr_word(im_q, exl_q == EXCLVL, ie_q) :
                    (A1 == CP0_CAUSE) ? cause_word(bd_q, ip_q, exc_q) :
                    (A1 == CP0_EPC)   ? epc_q :
                    (A1 == CP0_PRID)  ? PRID_VAL : '0;

    // next state: exception entry beats mtc0 (that instruction is flushed); eret clears EXL after any SR write
    always_comb begin
        exl_d = exl_q;
        im_d  = im_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        ip_d  = HWInt;
        if (IntReq) begin
            exl_d = EXCLVL;
            bd_d  = BD;
            exc_d = int_hit ? EXC_INT : ExcCode;
            epc_d = BD ? PC - 32'd4 : PC;
        end else begin
            if (WE && A2 == CP0_SR) begin
                im_d  = DIn[IM_HI:IM_LO];
                ie_d  = DIn[IE_BIT];
                exl_d = exl_e'(DIn[EXL_BIT]);
            end
            if (WE && A2 == CP0_EPC) epc_d = DIn;
            if (EXLClr) exl_d = NORMAL;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            exl_q <= NORMAL;
            im_q  <= IM_RST;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            exl_q <= exl_d;
            im_q  <= im_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

endmodule
